// File: rtl/frame_pkg.sv
// Shared definitions for the frame write-side scaler: mode encodings,
// per-mode decimation shift and the pixel-to-word packing ratio.
package frame_pkg;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2
  } mode_e;

  // log2 of the decimation factor in each axis; the unused code 3 behaves as 1:1.
  function automatic logic [1:0] mode_shift(input logic [1:0] mode);
    case (mode)
      MODE_HALF:    return 2'd1;
      MODE_QUARTER: return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction

  // Mode key cycles 1:1 -> 2:1 -> 4:1 -> 1:1.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      MODE_FULL: return MODE_HALF;
      MODE_HALF: return MODE_QUARTER;
      default:   return MODE_FULL;
    endcase
  endfunction

  // Number of pixel lanes in one packed memory word.
  function automatic int pack_ratio(input int mem_bits, input int pix_bits);
    return mem_bits / pix_bits;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for an active-low push key. The key is synchronised first, then
// a counter measures how long it has been held; one press pulse is produced
// per hold once the count reaches DEBOUNCE_CNT.
module key_debounce #(
  parameter int DEBOUNCE_CNT = 1485000,
  parameter int CNT_BITS     = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [CNT_BITS-1:0] TARGET = CNT_BITS'(DEBOUNCE_CNT);

  logic                key_s1_q, key_s2_q;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Count while held; stop one past the target so the pulse fires only once.
  always_comb begin
    cnt_d = cnt_q;
    if (key_s2_q) begin
      cnt_d = '0;
    end else if (cnt_q <= TARGET) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // Key synchroniser and hold counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      key_s1_q <= key_n_i;
      key_s2_q <= key_s1_q;
      cnt_q    <= cnt_d;
    end
  end

  // The counter sits on TARGET for exactly one cycle per hold.
  assign press_o = !key_s2_q && (cnt_q == TARGET);

endmodule

// File: rtl/frame_write_scaler.sv
// Write-side front end of the frame DDR3 path. Pixels are registered, their
// frame position tracked, decimated 1:1 / 2:1 / 4:1 in both axes according to
// the mode latched at each vsync, and packed LSB-first into memory words.
//
// Handshake: write_en is a valid with no ready -- every pixel is accepted.
// out_en is a one-cycle valid with no ready; out_full is sampled in the cycle
// a word is formed, and a word formed while out_full is high is dropped,
// not counted, and recorded in the sticky overflow flag.
module frame_write_scaler
  import frame_pkg::*;
#(
  parameter int WRITE_DATA_BITS = 16,
  parameter int MEM_DATA_BITS   = 64,
  parameter int H_ACTIVE        = 1920,
  parameter int V_ACTIVE        = 1080,
  parameter int POS_BITS        = 12,
  parameter int DEBOUNCE_CNT    = 1485000,
  parameter int CNT_BITS        = 24
) (
  input  logic                       write_clk,
  input  logic                       rst,
  input  logic                       wframe_vsync,
  input  logic                       mode_key,
  input  logic                       write_en,
  input  logic [WRITE_DATA_BITS-1:0] write_data,
  input  logic                       out_full,
  output logic                       out_en,
  output logic [MEM_DATA_BITS-1:0]   out_data,
  output logic [1:0]                 cur_mode,
  output logic                       frame_done,
  output logic                       frame_trunc,
  output logic [CNT_BITS-1:0]        word_count,
  output logic                       overflow
);

  localparam int RATIO     = pack_ratio(MEM_DATA_BITS, WRITE_DATA_BITS);
  localparam int LANE_BITS = $clog2(RATIO + 1);
  localparam logic [POS_BITS-1:0]  X_LAST = POS_BITS'(H_ACTIVE - 1);
  localparam logic [POS_BITS-1:0]  Y_LAST = POS_BITS'(V_ACTIVE - 1);
  localparam logic [LANE_BITS-1:0] LANE_FULL = LANE_BITS'(RATIO);

  logic                       vs_s1_q, vs_s2_q, vs_s3_q, vs_pos_q;
  logic                       vs_rise;
  logic                       press;
  logic [1:0]                 cur_mode_q, pending_q;
  logic                       s1_valid_q;
  logic [WRITE_DATA_BITS-1:0] s1_data_q;
  logic [POS_BITS-1:0]        x_q, x_d, y_q, y_d;
  logic [MEM_DATA_BITS-1:0]   pack_q, pack_d;
  logic [LANE_BITS-1:0]       lane_q, lane_d;
  logic                       out_en_q, out_en_d;
  logic [MEM_DATA_BITS-1:0]   out_data_q, out_data_d;
  logic                       frame_done_q, frame_done_d;
  logic                       frame_trunc_q, frame_trunc_d;
  logic [CNT_BITS-1:0]        word_count_q, word_count_d;
  logic                       overflow_q, overflow_d;

  logic [1:0]                 shift;
  logic [POS_BITS-1:0]        mask, px, py;
  logic                       keep, last, emit, counted;
  logic [MEM_DATA_BITS-1:0]   emit_data, base_pack;
  logic [LANE_BITS-1:0]       base_lane;
  logic [CNT_BITS-1:0]        base_wc;

  key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .CNT_BITS    (CNT_BITS)
  ) u_key_debounce (
    .clk_i  (write_clk),
    .rst_i  (rst),
    .key_n_i(mode_key),
    .press_o(press)
  );

  assign vs_rise = vs_s2_q && !vs_s3_q;

  // Vsync synchroniser and edge pulse; the mode is latched on the same edge
  // term so the new mode is in force in the cycle vs_pos is acted on.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      vs_s1_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      vs_s3_q    <= 1'b0;
      vs_pos_q   <= 1'b0;
      cur_mode_q <= MODE_FULL;
      pending_q  <= MODE_FULL;
    end else begin
      vs_s1_q  <= wframe_vsync;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      vs_pos_q <= vs_rise;
      if (vs_rise) cur_mode_q <= pending_q;
      if (press)   pending_q  <= next_mode(pending_q);
    end
  end

  // Stage 1: register the incoming pixel.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= write_en;
      s1_data_q  <= write_data;
    end
  end

  // Position tracking, keep decision, lane packing, flush and word accounting.
  always_comb begin
    shift = mode_shift(cur_mode_q);
    mask  = (POS_BITS'(1) << shift) - POS_BITS'(1);

    // A vsync edge restarts the frame; a pixel arriving with it is (0,0).
    px   = vs_pos_q ? '0 : x_q;
    py   = vs_pos_q ? '0 : y_q;
    keep = s1_valid_q && ((px & mask) == '0) && ((py & mask) == '0);
    last = s1_valid_q && (px == X_LAST) && (py == Y_LAST);

    frame_trunc_d = vs_pos_q && ((x_q != '0) || (y_q != '0));
    frame_done_d  = last;

    x_d = px;
    y_d = py;
    if (s1_valid_q) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = (py == Y_LAST) ? '0 : py + POS_BITS'(1);
      end else begin
        x_d = px + POS_BITS'(1);
      end
    end

    // On a vsync edge the old partial word is flushed as-is (upper lanes are
    // already zero) and packing restarts from an empty word.
    base_pack = vs_pos_q ? '0 : pack_q;
    base_lane = vs_pos_q ? '0 : lane_q;
    emit      = vs_pos_q && (lane_q != '0);
    emit_data = pack_q;
    counted   = 1'b0;
    pack_d    = base_pack;
    lane_d    = base_lane;

    if (keep) begin
      for (int i = 0; i < RATIO; i++) begin
        if (base_lane == LANE_BITS'(i)) begin
          pack_d[i*WRITE_DATA_BITS +: WRITE_DATA_BITS] = s1_data_q;
        end
      end
      lane_d = base_lane + LANE_BITS'(1);
    end

    // A full word, or whatever is left at the last pixel of the frame. A
    // flush can only be pending when RATIO > 1, in which case the first pixel
    // of a new frame never completes a word, so the two never coincide.
    if ((lane_d == LANE_FULL) || (last && (lane_d != '0))) begin
      emit      = 1'b1;
      emit_data = pack_d;
      counted   = 1'b1;
      pack_d    = '0;
      lane_d    = '0;
    end

    out_en_d   = emit && !out_full;
    out_data_d = out_en_d ? emit_data : '0;
    overflow_d = overflow_q || (emit && out_full);

    base_wc      = vs_pos_q ? '0 : word_count_q;
    word_count_d = base_wc;
    if (counted && !out_full && (base_wc != '1)) begin
      word_count_d = base_wc + CNT_BITS'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      pack_q        <= '0;
      lane_q        <= '0;
      out_en_q      <= 1'b0;
      out_data_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_trunc_q <= 1'b0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      pack_q        <= pack_d;
      lane_q        <= lane_d;
      out_en_q      <= out_en_d;
      out_data_q    <= out_data_d;
      frame_done_q  <= frame_done_d;
      frame_trunc_q <= frame_trunc_d;
      word_count_q  <= word_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_en      = out_en_q;
  assign out_data    = out_data_q;
  assign cur_mode    = cur_mode_q;
  assign frame_done  = frame_done_q;
  assign frame_trunc = frame_trunc_q;
  assign word_count  = word_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_frame_write_scaler.sv
// Bench for frame_write_scaler on a small 8x4 frame. A frame-level model
// turns each frame's pixel list into the expected word stream; a compare
// process checks every emitted word against it.
module tb_frame_write_scaler;

  localparam int W   = 16;
  localparam int M   = 64;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int PB  = 12;
  localparam int DEB = 10;
  localparam int CB  = 24;
  localparam int R   = M / W;

  logic          write_clk = 1'b0;
  logic          rst;
  logic          wframe_vsync;
  logic          mode_key;
  logic          write_en;
  logic [W-1:0]  write_data;
  logic          out_full;
  logic          out_en;
  logic [M-1:0]  out_data;
  logic [1:0]    cur_mode;
  logic          frame_done;
  logic          frame_trunc;
  logic [CB-1:0] word_count;
  logic          overflow;

  frame_write_scaler #(
    .WRITE_DATA_BITS(W),
    .MEM_DATA_BITS  (M),
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .POS_BITS       (PB),
    .DEBOUNCE_CNT   (DEB),
    .CNT_BITS       (CB)
  ) dut (
    .write_clk   (write_clk),
    .rst         (rst),
    .wframe_vsync(wframe_vsync),
    .mode_key    (mode_key),
    .write_en    (write_en),
    .write_data  (write_data),
    .out_full    (out_full),
    .out_en      (out_en),
    .out_data    (out_data),
    .cur_mode    (cur_mode),
    .frame_done  (frame_done),
    .frame_trunc (frame_trunc),
    .word_count  (word_count),
    .overflow    (overflow)
  );

  // Clock.
  always #5 write_clk = ~write_clk;

  int           checks = 0;
  int           failures = 0;
  logic [M-1:0] exp_q[$];
  logic [M-1:0] got_log[$];
  int           out_en_cnt = 0;
  int           done_cnt = 0;
  int           trunc_cnt = 0;
  int           done_with_word_cnt = 0;
  logic [W-1:0] pix[H*V];
  int           model_pending = 0;

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Compare process: every emitted word must be the next expected one.
  task automatic monitor();
    logic [M-1:0] e;
    forever begin
      @(negedge write_clk);
      if (out_en === 1'b1) begin
        out_en_cnt++;
        got_log.push_back(out_data);
        if (frame_done === 1'b1) done_with_word_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_word: got 0x%0h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL out_word: got 0x%0h expected 0x%0h", out_data, e);
          end
        end
      end
      if (frame_done === 1'b1) done_cnt++;
      if (frame_trunc === 1'b1) trunc_cnt++;
    end
  endtask

  // Frame-level model: keep every pixel whose coordinates are multiples of
  // the decimation factor, group into R-lane words, pad the remainder.
  // Word drop_idx is lost to backpressure. Only complete frames count the
  // padded remainder; a truncated frame's remainder is flushed uncounted.
  task automatic model_frame(input int n, input int mode, input int drop_idx, output int cnt);
    int nn;
    int lanes;
    int widx;
    logic [M-1:0] word;
    nn = 1 << mode;
    lanes = 0;
    widx = 0;
    cnt = 0;
    word = '0;
    for (int i = 0; i < n; i++) begin
      if (((i % H) % nn == 0) && ((i / H) % nn == 0)) begin
        word[lanes*W +: W] = pix[i];
        lanes++;
        if (lanes == R) begin
          if (widx != drop_idx) begin
            exp_q.push_back(word);
            cnt++;
          end
          widx++;
          lanes = 0;
          word = '0;
        end
      end
    end
    if (lanes > 0) begin
      exp_q.push_back(word);
      if (n == H * V) cnt++;
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < H * V; i++) pix[i] = W'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < H * V; i++) pix[i] = W'($urandom_range(0, 65535));
  endtask

  task automatic drive_pixels(input int n, input int gap_max, input int full_lo, input int full_hi);
    for (int i = 0; i < n; i++) begin
      int g;
      g = int'($urandom_range(0, gap_max));
      repeat (g) begin
        write_en = 1'b0;
        out_full = 1'b0;
        tick();
      end
      write_en   = 1'b1;
      write_data = pix[i];
      out_full   = (i >= full_lo) && (i <= full_hi);
      tick();
    end
    write_en = 1'b0;
    out_full = 1'b0;
  endtask

  task automatic press_key(input int len);
    mode_key = 1'b0;
    repeat (len) tick();
    mode_key = 1'b1;
    repeat (4) tick();
  endtask

  task automatic vsync_pulse();
    wframe_vsync = 1'b1;
    repeat (3) tick();
    wframe_vsync = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int base;
    int e0;
    int d0;
    int t0;
    int wc;
    int presses;
    fork
      monitor();
    join_none

    rst = 1'b1;
    wframe_vsync = 1'b0;
    mode_key = 1'b1;
    write_en = 1'b0;
    write_data = '0;
    out_full = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_out_en", out_en, 0);
    check("reset_out_data", out_data, 0);
    check("reset_cur_mode", cur_mode, 0);
    check("reset_word_count", word_count, 0);
    check("reset_overflow", overflow, 0);
    tick();

    // A: mode 0, index data, key press mid-frame.
    fill_index();
    model_frame(H * V, 0, -1, wc);
    base = got_log.size(); e0 = out_en_cnt; d0 = done_cnt;
    fork
      drive_pixels(H * V, 0, -1, -1);
      begin repeat (8) tick(); press_key(11); end
    join
    repeat (4) tick();
    check("A_words", out_en_cnt - e0, 8);
    check("A_first_word", got_log[base], 64'h0003_0002_0001_0000);
    check("A_frame_done", done_cnt - d0, 1);
    check("A_word_count", word_count, 8);
    check("A_word_count_model", word_count, wc);
    check("A_mode_unchanged", cur_mode, 0);
    model_pending = 1;

    // B: vsync latches mode 1 three cycles after the edge.
    wframe_vsync = 1'b1;
    tick(); tick();
    check("B_mode_before", cur_mode, 0);
    tick();
    check("B_mode_after", cur_mode, 1);
    repeat (2) tick();
    wframe_vsync = 1'b0;
    repeat (3) tick();
    check("B_wc_cleared", word_count, 0);
    check("B_no_trunc", trunc_cnt, 0);
    fill_index();
    model_frame(H * V, 1, -1, wc);
    base = got_log.size(); e0 = out_en_cnt; d0 = done_cnt;
    fork
      drive_pixels(H * V, 0, -1, -1);
      begin repeat (6) tick(); press_key(11); end
    join
    repeat (4) tick();
    check("B_words", out_en_cnt - e0, 2);
    check("B_first_word", got_log[base], 64'h0006_0004_0002_0000);
    check("B_word_count", word_count, 2);
    check("B_frame_done", done_cnt - d0, 1);
    model_pending = 2;

    // C: mode 2, single padded word emitted together with frame_done.
    vsync_pulse();
    check("C_mode", cur_mode, 2);
    fill_index();
    model_frame(H * V, 2, -1, wc);
    base = got_log.size(); e0 = out_en_cnt; d0 = done_with_word_cnt;
    fork
      drive_pixels(H * V, 0, -1, -1);
      begin repeat (6) tick(); press_key(12); end
    join
    repeat (4) tick();
    check("C_words", out_en_cnt - e0, 1);
    check("C_padded_word", got_log[base], 64'h0000_0000_0004_0000);
    check("C_done_with_word", done_with_word_cnt - d0, 1);
    check("C_word_count", word_count, 1);
    model_pending = 0;

    // D: mode 0, vsync after 13 pixels truncates the frame.
    vsync_pulse();
    check("D_mode", cur_mode, 0);
    fill_random();
    model_frame(13, 0, -1, wc);
    e0 = out_en_cnt; t0 = trunc_cnt;
    drive_pixels(13, 2, -1, -1);
    repeat (4) tick();
    check("D_words_before_vsync", out_en_cnt - e0, 3);
    check("D_wc_before_vsync", word_count, wc);
    vsync_pulse();
    check("D_trunc", trunc_cnt - t0, 1);
    check("D_words_after_vsync", out_en_cnt - e0, 4);
    check("D_flush_word", got_log[got_log.size() - 1], {48'd0, pix[12]});
    check("D_wc_after_vsync", word_count, 0);

    // E: out_full covers the forming of the second word.
    fill_random();
    model_frame(H * V, 0, 1, wc);
    e0 = out_en_cnt;
    drive_pixels(H * V, 0, 6, 9);
    repeat (4) tick();
    check("E_words", out_en_cnt - e0, 7);
    check("E_word_count", word_count, 7);
    check("E_word_count_model", word_count, wc);
    check("E_overflow", overflow, 1);

    // F: overflow stays sticky across a later clean frame.
    vsync_pulse();
    fill_random();
    model_frame(H * V, 0, -1, wc);
    drive_pixels(H * V, 2, -1, -1);
    repeat (4) tick();
    check("F_word_count", word_count, wc);
    check("F_overflow_sticky", overflow, 1);

    // G: reset in the middle of a word discards it without a flush.
    vsync_pulse();
    fill_index();
    model_frame(4, 0, -1, wc);
    drive_pixels(6, 0, -1, -1);
    tick();
    e0 = out_en_cnt;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("G_out_en", out_en, 0);
    check("G_out_data", out_data, 0);
    check("G_cur_mode", cur_mode, 0);
    check("G_frame_done", frame_done, 0);
    check("G_frame_trunc", frame_trunc, 0);
    check("G_word_count", word_count, 0);
    check("G_overflow", overflow, 0);
    repeat (4) tick();
    check("G_no_flush", out_en_cnt - e0, 0);
    check("G_exp_empty", exp_q.size(), 0);
    model_pending = 0;

    // H: fresh frame after reset matches scenario A.
    fill_index();
    model_frame(H * V, 0, -1, wc);
    base = got_log.size(); e0 = out_en_cnt; d0 = done_cnt;
    drive_pixels(H * V, 0, -1, -1);
    repeat (4) tick();
    check("H_words", out_en_cnt - e0, 8);
    check("H_first_word", got_log[base], 64'h0003_0002_0001_0000);
    check("H_frame_done", done_cnt - d0, 1);
    check("H_word_count", word_count, 8);

    // Random frames: random number of presses, random data and gaps.
    for (int f = 0; f < 4; f++) begin
      presses = int'($urandom_range(0, 2));
      for (int p = 0; p < presses; p++) press_key(11 + int'($urandom_range(0, 4)));
      model_pending = (model_pending + presses) % 3;
      vsync_pulse();
      check("RND_mode", cur_mode, model_pending);
      fill_random();
      model_frame(H * V, model_pending, -1, wc);
      d0 = done_cnt;
      drive_pixels(H * V, 2, -1, -1);
      repeat (4) tick();
      check("RND_word_count", word_count, wc);
      check("RND_frame_done", done_cnt - d0, 1);
    end

    repeat (5) tick();
    check("final_exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
